colossal_bus_master: RTL



---
 rtl/colossal_bus_master.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/colossal_bus_master.sv
// colossal_bus_master: turns burst commands into colossal pin sequences.
// Drives ui/uio with setup, strobe and hold timing and samples uo for reads.
module colossal_bus_master #(
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 1,
  parameter int READ_LAT  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_we,
  input  logic       cmd_bank,
  input  logic [5:0] cmd_addr,
  input  logic [5:0] cmd_len,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic [7:0] pin_ui,
  output logic [7:0] pin_uio,
  input  logic [7:0] pin_uo,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  localparam logic [15:0] SETUP_END = 16'(SETUP_CYC - 1);
  localparam logic [15:0] WE_END    = 16'(WE_CYC - 1);
  localparam logic [15:0] WAIT_END  = 16'(READ_LAT - 2);

  state_t      state;
  logic        we_q;
  logic        bank_q;
  logic [5:0]  addr_q;
  logic [5:0]  len_q;
  logic        have_data;
  logic [15:0] cnt;
  logic        beat_done;

  assign beat_done = (state == HOLD) ||
                     (state == RESP && rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      bank_q    <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      have_data <= 1'b0;
      cnt       <= '0;
      pin_ui    <= '0;
      pin_uio   <= '0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            we_q      <= cmd_we;
            bank_q    <= cmd_bank;
            addr_q    <= cmd_addr;
            len_q     <= cmd_len;
            pin_ui    <= {1'b0, cmd_bank, cmd_addr};
            cmd_ready <= 1'b0;
            wr_ready  <= cmd_we;
            have_data <= !cmd_we;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          // setup time only counts once the data beat sits on uio
          if (!have_data) begin
            if (wr_valid && wr_ready) begin
              pin_uio   <= wr_data;
              wr_ready  <= 1'b0;
              have_data <= 1'b1;
              cnt       <= '0;
            end
          end else if (cnt == SETUP_END) begin
            cnt <= '0;
            if (we_q) begin
              pin_ui[7] <= 1'b1;
              state     <= STROBE;
            end else if (READ_LAT == 1) begin
              state <= CAPTURE;
            end else begin
              state <= WAIT;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STROBE: begin
          if (cnt == WE_END) begin
            pin_ui[7] <= 1'b0;
            cnt       <= '0;
            state     <= HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: ;
        WAIT: begin
          if (cnt == WAIT_END) begin
            cnt   <= '0;
            state <= CAPTURE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        CAPTURE: begin
          rsp_data  <= pin_uo;
          rsp_valid <= 1'b1;
          rsp_last  <= (len_q == 6'd0);
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // cmd_ready stays low for the first IDLE cycle
      if (beat_done) begin
        if (len_q == 6'd0) begin
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          addr_q    <= addr_q + 6'd1;
          len_q     <= len_q - 6'd1;
          pin_ui    <= {1'b0, bank_q, addr_q + 6'd1};
          wr_ready  <= we_q;
          have_data <= !we_q;
          cnt       <= '0;
          state     <= SETUP;
        end
      end
    end
  end

endmodule
